// File: rtl/sc_matrix_scan_tx_pkg.sv
// ============================================================================
//  Module      : sc_matrix_scan_tx_pkg
//  Description : MAX7219 register map, init frame table and FSM state codes
//                shared by the matrix scan transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sc_matrix_scan_tx_pkg;

    localparam logic [7:0] c_REG_DIGIT0    = 8'h01;
    localparam logic [7:0] c_REG_DECODE    = 8'h09;
    localparam logic [7:0] c_REG_INTENSITY = 8'h0A;
    localparam logic [7:0] c_REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] c_REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] c_REG_TEST      = 8'h0F;

    localparam int c_INIT_FRAMES = 5;

    localparam int         c_STW      = 3;
    localparam logic [2:0] c_ST_INIT  = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_FETCH = 3'd2;
    localparam logic [2:0] c_ST_SHIFT = 3'd3;
    localparam logic [2:0] c_ST_LATCH = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } maxFrame_t;

    function automatic maxFrame_t initFrame(input logic [2:0] idx,
                                            input logic [2:0] scanLimit,
                                            input logic [3:0] intensity);
        maxFrame_t f;
        case (idx)
            3'd0:    f = '{addr: c_REG_SHUTDOWN,  data: 8'h01};
            3'd1:    f = '{addr: c_REG_TEST,      data: 8'h00};
            3'd2:    f = '{addr: c_REG_DECODE,    data: 8'h00};
            3'd3:    f = '{addr: c_REG_SCANLIMIT, data: {5'h00, scanLimit}};
            default: f = '{addr: c_REG_INTENSITY, data: {4'h0, intensity}};
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sc_matrix_scan_tx_if.sv
// ============================================================================
//  Module      : sc_matrix_scan_tx_if
//  Description : Row-bank handshake and 3-wire SPI pins of the matrix
//                transmitter; master = transmitter side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sc_matrix_scan_tx_if;

    logic       SC_MatrixTX_start_InLow;
    logic [7:0] SC_MatrixTX_rowdata_InBUS;
    logic [2:0] SC_MatrixTX_rowsel_OutBUS;
    logic       SC_MatrixTX_busy_Out;
    logic       SC_MatrixTX_done_OutLow;
    logic       SC_MatrixTX_spi_din_Out;
    logic       SC_MatrixTX_spi_clk_Out;
    logic       SC_MatrixTX_spi_load_Out;

    modport master (
        input  SC_MatrixTX_start_InLow, SC_MatrixTX_rowdata_InBUS,
        output SC_MatrixTX_rowsel_OutBUS, SC_MatrixTX_busy_Out, SC_MatrixTX_done_OutLow,
               SC_MatrixTX_spi_din_Out, SC_MatrixTX_spi_clk_Out, SC_MatrixTX_spi_load_Out
    );

    modport slave (
        output SC_MatrixTX_start_InLow, SC_MatrixTX_rowdata_InBUS,
        input  SC_MatrixTX_rowsel_OutBUS, SC_MatrixTX_busy_Out, SC_MatrixTX_done_OutLow,
               SC_MatrixTX_spi_din_Out, SC_MatrixTX_spi_clk_Out, SC_MatrixTX_spi_load_Out
    );

endinterface

`default_nettype wire

// File: rtl/sc_spi_frame_shifter.sv
// ============================================================================
//  Module      : sc_spi_frame_shifter
//  Description : 16-bit MSB-first PISO with CLKDIV half-period timing, followed
//                by a load-low / load-high latch phase.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sc_spi_frame_shifter #(
    parameter int CLKDIV = 2
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_start,
    input  wire logic [15:0] i_word,
    output logic             o_shiftDone,
    output logic             o_frameDone,
    output logic             o_din,
    output logic             o_sck,
    output logic             o_load
);

    localparam int                c_DIVW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [c_DIVW-1:0] c_DIV_LAST = c_DIVW'(CLKDIV - 1);

    logic [15:0]       r_sr;
    logic [c_DIVW-1:0] r_div;
    logic [3:0]        r_bit;
    logic              r_active;
    logic              r_latch;
    logic              r_latchHi;
    logic              r_din;
    logic              r_sck;
    logic              r_load;
    logic              w_divLast;

    assign w_divLast   = (r_div == c_DIV_LAST);
    assign o_shiftDone = r_active & ~r_latch & r_sck & w_divLast & (r_bit == 4'd15);
    assign o_frameDone = r_active & r_latch & r_latchHi & w_divLast;
    assign o_din       = r_din;
    assign o_sck       = r_sck;
    assign o_load      = r_load;

    // Pin registers reset asynchronously so the link goes idle mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr      <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            r_active  <= 1'b0;
            r_latch   <= 1'b0;
            r_latchHi <= 1'b0;
            r_din     <= 1'b0;
            r_sck     <= 1'b0;
            r_load    <= 1'b1;
        end else if (i_start) begin
            r_sr      <= i_word;
            r_din     <= i_word[15];
            r_sck     <= 1'b0;
            r_load    <= 1'b0;
            r_div     <= '0;
            r_bit     <= '0;
            r_active  <= 1'b1;
            r_latch   <= 1'b0;
            r_latchHi <= 1'b0;
        end else if (r_active) begin
            if (!w_divLast) begin
                r_div <= r_div + c_DIVW'(1);
            end else begin
                r_div <= '0;
                if (r_latch) begin
                    if (r_latchHi) begin
                        r_active <= 1'b0;
                    end else begin
                        r_latchHi <= 1'b1;
                        r_load    <= 1'b1;
                    end
                end else if (!r_sck) begin
                    r_sck <= 1'b1;
                end else begin
                    r_sck <= 1'b0;
                    if (r_bit == 4'd15) begin
                        r_latch <= 1'b1;
                        r_din   <= 1'b0;
                    end else begin
                        r_bit <= r_bit + 4'd1;
                        r_sr  <= {r_sr[14:0], 1'b0};
                        r_din <= r_sr[14];
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sc_matrix_scan_tx.sv
// ============================================================================
//  Module      : sc_matrix_scan_tx
//  Description : Walks the row registers and streams each row as a MAX7219
//                digit frame; runs the 5-frame init sequence after reset.
//                Define SC_MATRIXTX_MIRROR_EN to bit-reverse row data.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sc_matrix_scan_tx
    import sc_matrix_scan_tx_pkg::*;
#(
    parameter int         ROWS           = 8,
    parameter int         DATAWIDTH      = 8,
    parameter int         CLKDIV         = 2,
    parameter logic [3:0] INIT_INTENSITY = 4'h8
) (
    input  wire logic            SC_MatrixTX_CLOCK_50,
    input  wire logic            SC_MatrixTX_RESET_InLow,
    sc_matrix_scan_tx_if.master  matrixBus
);

    localparam logic [2:0] c_SCAN_LIMIT = 3'(ROWS - 1);
    localparam logic [2:0] c_ROW_LAST   = 3'(ROWS - 1);
    localparam logic [2:0] c_INIT_LAST  = 3'(c_INIT_FRAMES - 1);

    logic [c_STW-1:0]     r_state;
    logic [2:0]           r_row;
    logic [2:0]           r_rowsel;
    logic [2:0]           r_initIdx;
    logic                 r_initMode;
    logic                 r_busy;
    logic                 r_done;
    logic [DATAWIDTH-1:0] w_rowData;
    logic [3:0]           w_addr;
    maxFrame_t            w_initFrame;
    logic [15:0]          w_word;
    logic                 w_shiftDone;
    logic                 w_frameDone;

`ifdef SC_MATRIXTX_MIRROR_EN
    for (genvar i = 0; i < DATAWIDTH; i++) begin : g_mirror
        assign w_rowData[i] = matrixBus.SC_MatrixTX_rowdata_InBUS[DATAWIDTH-1-i];
    end
`else
    assign w_rowData = matrixBus.SC_MatrixTX_rowdata_InBUS[DATAWIDTH-1:0];
`endif

    assign w_addr      = {1'b0, r_rowsel} + 4'd1;
    assign w_initFrame = initFrame(r_initIdx, c_SCAN_LIMIT, INIT_INTENSITY);
    assign w_word      = r_initMode ? 16'(w_initFrame) : {4'h0, w_addr, w_rowData};

    sc_spi_frame_shifter #(.CLKDIV(CLKDIV)) u_shifter (
        .clk         (SC_MatrixTX_CLOCK_50),
        .rst_n       (SC_MatrixTX_RESET_InLow),
        .i_start     (r_state == c_ST_FETCH),
        .i_word      (w_word),
        .o_shiftDone (w_shiftDone),
        .o_frameDone (w_frameDone),
        .o_din       (matrixBus.SC_MatrixTX_spi_din_Out),
        .o_sck       (matrixBus.SC_MatrixTX_spi_clk_Out),
        .o_load      (matrixBus.SC_MatrixTX_spi_load_Out)
    );

    assign matrixBus.SC_MatrixTX_rowsel_OutBUS = r_rowsel;
    assign matrixBus.SC_MatrixTX_busy_Out      = r_busy;
    assign matrixBus.SC_MatrixTX_done_OutLow   = r_done;

    // r_row points at the next row to fetch; it wrapping to 0 ends the refresh.
    always_ff @(posedge SC_MatrixTX_CLOCK_50 or negedge SC_MatrixTX_RESET_InLow) begin
        if (!SC_MatrixTX_RESET_InLow) begin
            r_state    <= c_ST_INIT;
            r_row      <= '0;
            r_rowsel   <= '0;
            r_initIdx  <= '0;
            r_initMode <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b1;
        end else begin
            case (r_state)
                c_ST_INIT: begin
                    r_state    <= c_ST_FETCH;
                    r_initMode <= 1'b1;
                    r_initIdx  <= '0;
                end
                c_ST_IDLE: begin
                    if (!matrixBus.SC_MatrixTX_start_InLow) begin
                        r_state  <= c_ST_FETCH;
                        r_busy   <= 1'b1;
                        r_rowsel <= r_row;
                    end
                end
                c_ST_FETCH: begin
                    r_state <= c_ST_SHIFT;
                    if (!r_initMode) begin
                        r_row <= (r_row == c_ROW_LAST) ? 3'd0 : r_row + 3'd1;
                    end
                end
                c_ST_SHIFT: begin
                    if (w_shiftDone) begin
                        r_state <= c_ST_LATCH;
                    end
                end
                c_ST_LATCH: begin
                    if (w_frameDone) begin
                        if (r_initMode) begin
                            if (r_initIdx == c_INIT_LAST) begin
                                r_initMode <= 1'b0;
                                r_state    <= c_ST_IDLE;
                                r_busy     <= 1'b0;
                            end else begin
                                r_initIdx <= r_initIdx + 3'd1;
                                r_state   <= c_ST_FETCH;
                            end
                        end else if (r_row == 3'd0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b0;
                        end else begin
                            r_state  <= c_ST_FETCH;
                            r_rowsel <= r_row;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_INIT;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
